// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory access sequencer.
//   - default widths and timeout
//   - FSM state encoding
//   - polarity of the decoder's active-low control strobes
package dmem_pkg;

   localparam int unsigned DMEM_ADDR_W  = 32;
   localparam int unsigned DMEM_DATA_W  = 32;
   localparam int unsigned DMEM_TIMEOUT = 255;
   localparam int unsigned DMEM_TO_W    = 8;

   localparam logic [1:0] ST_IDLE = 2'b00;
   localparam logic [1:0] ST_BUSY = 2'b01;
   localparam logic [1:0] ST_DONE = 2'b10;

   typedef enum logic [1:0] {
      IDLE = ST_IDLE,
      BUSY = ST_BUSY,
      DONE = ST_DONE
   } state_e;

   // Decoder strobes are active-low: 0 means the strobe is asserted.
   localparam logic CTRL_ASSERTED = 1'b0;

endpackage

// File: rtl/dmem_if.sv
// Request/ready bus between the access sequencer and the data memory.
//   master (sequencer): drives mem_req, mem_we, mem_addr, mem_wdata
//   slave  (memory)   : drives mem_ready, mem_rdata (rdata valid with ready)
interface dmem_if import dmem_pkg::*; #(
   parameter int unsigned ADDR_W = DMEM_ADDR_W,
   parameter int unsigned DATA_W = DMEM_DATA_W
);

   logic              mem_req;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic              mem_ready;
   logic [DATA_W-1:0] mem_rdata;

   modport master (
      output mem_req, mem_we, mem_addr, mem_wdata,
      input  mem_ready, mem_rdata
   );

   modport slave (
      input  mem_req, mem_we, mem_addr, mem_wdata,
      output mem_ready, mem_rdata
   );

endinterface

// File: rtl/dmem_timeout_cnt.sv
// Counts cycles spent waiting on the memory.
//   clk, rst_n : clock, synchronous active-low reset
//   clr_i      : return count to zero (priority over en_i)
//   en_i       : count this cycle
//   hit_c_o    : combinational; this enabled cycle is the TIMEOUT-th one
module dmem_timeout_cnt import dmem_pkg::*; #(
   parameter int unsigned TO_W    = DMEM_TO_W,
   parameter int unsigned TIMEOUT = DMEM_TIMEOUT
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr_i,
   input  logic en_i,
   output logic hit_c_o
);

   logic [TO_W-1:0] cnt_q;
   logic [TO_W-1:0] cnt_d;

   // Count register holds cycles already completed, so the current cycle is cnt_q+1.
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i) begin
         cnt_d = cnt_q + TO_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign hit_c_o = en_i && (cnt_q == TO_W'(TIMEOUT - 1));

endmodule

// File: rtl/dmem_access_ctrl.sv
// Data-memory access sequencer between the control decoder and data memory.
//   clk, rst_n        : clock, synchronous active-low reset
//   mem_enable_n_i    : decoder strobe, 0 = load/store this instruction
//   mem_read_n_i      : decoder strobe, 0 = load
//   mem_write_n_i     : decoder strobe, 0 = store
//   addr_i, wdata_i   : effective address and store data
//   stall_o           : hold the pipeline (combinational in the detect cycle)
//   rdata_o           : load result to write-back
//   err_o, err_clr_i  : sticky timeout/illegal-strobe flag and its clear
//   mem_bus           : request/ready bus to the data memory
module dmem_access_ctrl import dmem_pkg::*; #(
   parameter int unsigned ADDR_W  = DMEM_ADDR_W,
   parameter int unsigned DATA_W  = DMEM_DATA_W,
   parameter int unsigned TIMEOUT = DMEM_TIMEOUT,
   parameter int unsigned TO_W    = DMEM_TO_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              mem_enable_n_i,
   input  logic              mem_read_n_i,
   input  logic              mem_write_n_i,
   input  logic [ADDR_W-1:0] addr_i,
   input  logic [DATA_W-1:0] wdata_i,
   output logic              stall_o,
   output logic [DATA_W-1:0] rdata_o,
   output logic              err_o,
   input  logic              err_clr_i,
   dmem_if.master            mem_bus
);

   state_e            state_q, state_d;
   logic              req_q, req_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic              err_q, err_d;
   logic              err_set;
   logic              acc;
   logic              ill;
   logic              busy;
   logic              to_hit;

   // Exactly one of read/write asserted is an access; both asserted is illegal.
   assign acc = (mem_enable_n_i == CTRL_ASSERTED) && (mem_read_n_i ^ mem_write_n_i);
   assign ill = (mem_enable_n_i == CTRL_ASSERTED) && (mem_read_n_i == CTRL_ASSERTED)
                && (mem_write_n_i == CTRL_ASSERTED);

   assign busy = (state_q == BUSY);

   dmem_timeout_cnt #(
      .TO_W    (TO_W),
      .TIMEOUT (TIMEOUT)
   ) u_timeout_cnt (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr_i   (!busy),
      .en_i    (busy),
      .hit_c_o (to_hit)
   );

   // Next-state, latches and stall.
   always_comb begin
      state_d = state_q;
      req_d   = req_q;
      we_d    = we_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      err_set = 1'b0;
      stall_o = 1'b0;

      case (state_q)
         IDLE: begin
            if (acc) begin
               addr_d  = addr_i;
               wdata_d = wdata_i;
               we_d    = (mem_write_n_i == CTRL_ASSERTED);
               req_d   = 1'b1;
               stall_o = 1'b1;
               state_d = BUSY;
            end else if (ill) begin
               err_set = 1'b1;
            end
         end
         BUSY: begin
            stall_o = 1'b1;
            // Ready takes priority over a timeout landing on the same cycle.
            if (mem_bus.mem_ready) begin
               req_d   = 1'b0;
               if (!we_q) begin
                  rdata_d = mem_bus.mem_rdata;
               end
               state_d = DONE;
            end else if (to_hit) begin
               req_d   = 1'b0;
               err_set = 1'b1;
               if (!we_q) begin
                  rdata_d = '0;
               end
               state_d = DONE;
            end
         end
         DONE: begin
            // Core advances on this edge; strobes still show the finished instruction.
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // A new error outranks a clear issued in the same cycle.
      if (err_set) begin
         err_d = 1'b1;
      end else if (err_clr_i) begin
         err_d = 1'b0;
      end else begin
         err_d = err_q;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         req_q   <= 1'b0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         req_q   <= req_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end

   assign mem_bus.mem_req   = req_q;
   assign mem_bus.mem_we    = we_q;
   assign mem_bus.mem_addr  = addr_q;
   assign mem_bus.mem_wdata = wdata_q;
   assign rdata_o           = rdata_q;
   assign err_o             = err_q;

endmodule

// File: doc/dmem_access_ctrl.md
Name: dmem_access_ctrl

Overview:
Data-memory access sequencer sitting directly downstream of the instruction control decoder. Consumes the decoder's active-low mem_enable/mem_read/mem_write strobes plus ALU address and store data, and runs a req/ready handshake to a variable-latency data memory. Stalls the core until the access completes, then returns load data. Flags timeouts and illegal strobe combinations.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
TIMEOUT, 255, max BUSY cycles waiting for mem_ready before abort (>=1)
TO_W, 8, timeout counter width; must hold TIMEOUT

Ports:
clk  in  1  core clock
rst_n  in  1  synchronous active-low reset
mem_enable_n  in  1  from control decoder; 0 = LW/SW this instruction
mem_read_n  in  1  from control decoder; 0 = load
mem_write_n  in  1  from control decoder; 0 = store
addr  in  ADDR_W  ALU result (effective address)
wdata  in  DATA_W  store data (rt)
stall  out  1  hold PC/pipeline while 1
rdata  out  DATA_W  load result to write-back mux
err  out  1  sticky error (timeout or illegal strobes)
err_clr  in  1  clears err
mem_req  out  1  request to data memory
mem_we  out  1  1 = write
mem_addr  out  ADDR_W  latched address
mem_wdata  out  DATA_W  latched store data
mem_ready  in  1  memory completion
mem_rdata  in  DATA_W  memory read data, valid with mem_ready

Behaviour:
- Clock clk, reset rst_n: one clock; reset synchronous, active-low.
- Reset values: state IDLE; stall 0, mem_req 0, mem_we 0, mem_addr 0, mem_wdata 0, rdata 0, err 0, timeout counter 0.
- acc = !mem_enable_n & (mem_read_n ^ mem_write_n); ill = !mem_enable_n & !mem_read_n & !mem_write_n. mem_enable_n=0 with both read_n/write_n high: ignored, no error.
- States: IDLE, BUSY, DONE.
- IDLE: if acc, latch addr, wdata, we=!mem_write_n; go BUSY; stall=1 combinationally this cycle. If ill, set err, stay IDLE, stall 0, no request.
- BUSY: mem_req=1, stall=1; mem_addr/mem_wdata/mem_we stable. Decoder inputs ignored. Counter increments each BUSY cycle.
- mem_ready=1 in BUSY: for a read, rdata <= mem_rdata; go DONE; mem_req drops on the next edge.
- Counter reaches TIMEOUT without ready: mem_req drops, err set, rdata <= 0 for a read; go DONE. If ready and timeout hit on the same cycle, ready wins with no error.
- DONE: stall=0, mem_req=0; the core advances at this edge. Decoder inputs are ignored, with no retrigger on the same instruction. Next state IDLE, counter cleared.
- Minimum latency: ready on the first BUSY cycle gives 2 stall cycles (IDLE-detect, BUSY), then DONE.
- rdata holds its value except on read completion or read timeout. Stores never modify rdata.
- err is sticky. err_clr clears it; a set in the same cycle as err_clr wins.
- mem_ready outside BUSY is ignored.
- Reset mid-access: return to reset values on the next edge, abandoning the request. The memory must tolerate req dropping before ready.

Decomposition:
- Shared package dmem_pkg:
  - state encoding localparams: IDLE=2'b00, BUSY=2'b01, DONE=2'b10
  - active-low strobe constant: CTRL_ASSERTED=1'b0
- Sub-module dmem_timeout_cnt: TO_W counter with clear/enable and a hit output at TIMEOUT.
- FSM, latches and output muxing stay in dmem_access_ctrl.

Test Plan:
1. LW: enable_n=0, read_n=0, addr=0x10; ready on first BUSY cycle with mem_rdata=0xDEADBEEF -> mem_req 1 cycle, mem_we=0, stall 2 cycles, rdata=0xDEADBEEF in DONE, err=0.
2. SW: addr=0x20, wdata=0x12345678; ready on 4th BUSY cycle; addr toggled during BUSY -> mem_we=1, mem_addr=0x20/mem_wdata stable all 4 cycles, stall 5 cycles, rdata unchanged.
3. Timeout: TIMEOUT=4, LW, ready never -> mem_req high exactly 4 cycles, err=1, rdata=0, stall released in DONE. err_clr pulse -> err=0.
4. Illegal: enable_n=0, read_n=0, write_n=0 -> mem_req never asserts, stall=0, err=1. Ready arriving together with timeout -> err stays 0.
5. Reset mid-BUSY: rst_n=0 for 1 cycle at 2nd BUSY cycle -> next edge stall=0, mem_req=0, rdata=0, err=0. Following LW completes normally in 2 stall cycles.
6. Back-to-back LW then SW, mem_ready tied 1 -> each access 2 stall cycles, exactly one mem_req pulse per instruction, no retrigger in DONE.
